// File: rtl/ffe_pkg.sv
// Shared constants and state encoding for the FFE tap-select datapath
// (sequencer, tap multiplexer and MAC).
package ffe_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int NUM_TAPS   = 4;
    localparam int SEL_WIDTH  = 2;
    localparam int FILL_WIDTH = 3;

    localparam logic [SEL_WIDTH-1:0]  SEL_LAST = SEL_WIDTH'(NUM_TAPS - 1);
    localparam logic [FILL_WIDTH-1:0] FILL_MAX = FILL_WIDTH'(NUM_TAPS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ffe_tap_delay_line.sv
// Four-deep sample delay line with a saturating fill counter; unfilled taps
// read zero so the FFE starts up zero-padded.
module ffe_tap_delay_line
    import ffe_pkg::*;
(
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] tap0,
    output logic [DATA_WIDTH-1:0] tap1,
    output logic [DATA_WIDTH-1:0] tap2,
    output logic [DATA_WIDTH-1:0] tap3,
    output logic                  primed
);

    logic [FILL_WIDTH-1:0] fill_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            tap0     <= '0;
            tap1     <= '0;
            tap2     <= '0;
            tap3     <= '0;
            fill_cnt <= '0;
        end else if (shift) begin
            tap3 <= tap2;
            tap2 <= tap1;
            tap1 <= tap0;
            tap0 <= in_data;
            if (fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + FILL_WIDTH'(1);
            end
        end
    end

    assign primed = (fill_cnt == FILL_MAX);

endmodule

// File: rtl/ffe_tap_sequencer.sv
// Feeds the FFE tap mux and MAC: one sample accepted per 4-term pass, taps held
// stable while sel walks 0..3, with clr/last strobes framing each output.
module ffe_tap_sequencer
    import ffe_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] tap0,
    output logic [DATA_WIDTH-1:0] tap1,
    output logic [DATA_WIDTH-1:0] tap2,
    output logic [DATA_WIDTH-1:0] tap3,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic                  mac_last,
    output logic                  primed,
    output state_t                dbg_state
);

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // the source must hold in_valid/in_data stable until that edge, and in_ready
    // never depends on in_valid.
    state_t               state, state_n;
    logic [SEL_WIDTH-1:0] sel_n;
    logic                 accept;

    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        if (flush) begin
            state_n = IDLE;
            sel_n   = '0;
        end else if (accept) begin
            state_n = RUN;
            sel_n   = '0;
        end else if (state == RUN) begin
            if (sel == SEL_LAST) begin
                state_n = IDLE;
                sel_n   = '0;
            end else begin
                sel_n = sel + SEL_WIDTH'(1);
            end
        end
    end

    // Accepting only on the final term keeps taps stable for the whole pass.
    always_comb begin
        in_ready = !RST && !flush && (state == IDLE || sel == SEL_LAST);
        mac_en   = (state == RUN);
        mac_clr  = (state == RUN) && (sel == '0);
        mac_last = (state == RUN) && (sel == SEL_LAST);
    end

    ffe_tap_delay_line u_delay_line (
        .clk     (CLK),
        .clear   (RST || flush),
        .shift   (accept),
        .in_data (in_data),
        .tap0    (tap0),
        .tap1    (tap1),
        .tap2    (tap2),
        .tap3    (tap3),
        .primed  (primed)
    );

endmodule
